warpv_pcpi_dispatch: RTL and testbench

Upstream PCPI dispatch stage between the core's M-extension issue point and the PCPI co-processors (multiplier unit and `picorv32`-style divider unit). It accepts one instruction at a time from the core over a valid/ready handshake and broadcasts it on the PCPI bus. It holds `pcpi_valid` until a unit answers, then captures that unit's result into a response register. If no unit claims the instruction within a timeout, it raises an illegal-instruction trap.

---
 rtl/warpv_pcpi_dispatch.sv | 138 +++++++++++++
 tb/tb_warpv_pcpi_dispatch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warpv_pcpi_dispatch.sv
// PCPI dispatch stage: accepts one M-extension instruction from the core, broadcasts it
// to the PCPI units, captures the first unit answer, or traps if nobody claims it in time.
module warpv_pcpi_dispatch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_wr,
  output logic [31:0] resp_rd,
  output logic        resp_trap,
  input  logic        resp_ready,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        mul_wr,
  input  logic        mul_wait,
  input  logic        mul_ready,
  input  logic [31:0] mul_rd,
  input  logic        div_wr,
  input  logic        div_wait,
  input  logic        div_ready,
  input  logic [31:0] div_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] tmo_cnt;
  logic       seen_wait;
  logic       in_idle, in_issue, in_done;
  logic       any_wait, any_ready, expire;
  logic       accept, finish_ok, finish_trap;

  // The unused encoding 2'b11 falls through to the IDLE decode.
  assign in_issue = (state == S_ISSUE);
  assign in_done  = (state == S_DONE);
  assign in_idle  = !in_issue && !in_done;

  assign req_ready = in_idle;
  assign busy      = !in_idle;

  assign any_wait  = mul_wait | div_wait;
  assign any_ready = mul_ready | div_ready;
  assign expire    = !seen_wait && !any_wait && !any_ready && (tmo_cnt == TMO_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next  = state;
    accept      = 1'b0;
    finish_ok   = 1'b0;
    finish_trap = 1'b0;
    if (in_idle) begin
      state_next = S_IDLE;
      if (req_valid) begin
        state_next = S_ISSUE;
        accept     = 1'b1;
      end
    end else if (in_issue) begin
      // A ready in the expiry cycle takes precedence over the trap.
      if (any_ready) begin
        state_next = S_DONE;
        finish_ok  = 1'b1;
      end else if (expire) begin
        state_next  = S_DONE;
        finish_trap = 1'b1;
      end
    end else if (resp_ready) begin
      state_next = S_IDLE;
    end
  end

  // NOTE: reset is synchronous and sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      seen_wait  <= 1'b0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rd    <= '0;
      resp_trap  <= 1'b0;
    end else begin
      state      <= state_next;
      pcpi_valid <= (state_next == S_ISSUE);
      resp_valid <= (state_next == S_DONE);

      if (accept) begin
        pcpi_insn <= req_insn;
        pcpi_rs1  <= req_rs1;
        pcpi_rs2  <= req_rs2;
        tmo_cnt   <= '0;
        seen_wait <= 1'b0;
      end

      if (in_issue) begin
        if (any_wait) seen_wait <= 1'b1;
        if (!seen_wait && !any_wait && !any_ready) tmo_cnt <= tmo_cnt + 8'd1;
      end

      // Divider rd is zeroed once pcpi_valid drops, so the result must be latched here.
      if (finish_ok) begin
        resp_trap <= 1'b0;
        if (mul_ready) begin
          resp_wr <= mul_wr;
          resp_rd <= mul_rd;
        end else begin
          resp_wr <= div_wr;
          resp_rd <= div_rd;
        end
      end

      if (finish_trap) begin
        resp_trap <= 1'b1;
        resp_wr   <= 1'b0;
        resp_rd   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_warpv_pcpi_dispatch.sv
// Table-driven bench for warpv_pcpi_dispatch with a cycle-level divider model and a
// multiplier stub whose behaviour is selected per vector.
module tb_warpv_pcpi_dispatch;

  localparam int TIMEOUT = 16;
  localparam int DIV_LAT = 32;
  localparam int BOUND   = 200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
  logic        req_ready;
  logic        resp_valid, resp_wr, resp_trap;
  logic [31:0] resp_rd;
  logic        resp_ready = 1'b0;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        mul_wr, mul_wait, mul_ready;
  logic [31:0] mul_rd;
  logic        div_wr, div_wait, div_ready;
  logic [31:0] div_rd;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int mul_mode = 0;  // 0: silent, 1: ready one cycle after valid, 2: ready with div_ready

  always #5 clk = ~clk;

  warpv_pcpi_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rd(resp_rd), .resp_trap(resp_trap),
    .resp_ready(resp_ready),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .mul_wr(mul_wr), .mul_wait(mul_wait), .mul_ready(mul_ready), .mul_rd(mul_rd),
    .div_wr(div_wr), .div_wait(div_wait), .div_ready(div_ready), .div_rd(div_rd),
    .busy(busy)
  );

  // ---------------- PCPI unit models ----------------
  function automatic logic is_div(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
  endfunction

  function automatic logic [31:0] div_calc(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  logic d_dec, pv_q;
  int   d_cnt;

  assign mul_wait = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      d_dec <= 1'b0; d_cnt <= 0; pv_q <= 1'b0;
      div_wait <= 1'b0; div_ready <= 1'b0; div_wr <= 1'b0; div_rd <= '0;
      mul_ready <= 1'b0; mul_wr <= 1'b0; mul_rd <= '0;
    end else begin
      pv_q      <= pcpi_valid;
      div_ready <= 1'b0; div_wr <= 1'b0; div_rd <= '0;
      mul_ready <= 1'b0; mul_wr <= 1'b0; mul_rd <= '0;
      // Decodes whenever valid is high and it is not already working on an instruction.
      d_dec <= pcpi_valid && is_div(pcpi_insn) && !d_dec && !div_wait && !div_ready;
      if (d_dec) begin
        div_wait <= 1'b1;
        d_cnt    <= DIV_LAT;
      end else if (div_wait) begin
        if (d_cnt == 0) begin
          div_wait  <= 1'b0;
          div_ready <= 1'b1;
          div_wr    <= 1'b1;
          div_rd    <= div_calc(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2);
          if (mul_mode == 2) begin
            mul_ready <= 1'b1; mul_wr <= 1'b1; mul_rd <= 32'h1234_5678;
          end
        end else begin
          d_cnt <= d_cnt - 1;
        end
      end
      if (mul_mode == 1 && pcpi_valid && !pv_q) begin
        mul_ready <= 1'b1; mul_wr <= 1'b1; mul_rd <= 32'h1234_5678;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          mode;
    logic [31:0] rd;
    logic        wr;
    logic        trap;
    int          lat;   // cycles from acceptance edge to resp_valid, 0 = not checked
    int          hold;  // cycles resp_ready is held low in DONE
  } vec_t;

  // Issues one instruction, waits for the response, checks it and consumes it.
  task automatic do_op(input vec_t v);
    int   n;
    logic div_seen;
    mul_mode  = v.mode;
    req_insn  = v.insn;
    req_rs1   = v.rs1;
    req_rs2   = v.rs2;
    req_valid = 1'b1;
    check({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check({v.name, ".pcpi_valid"}, 32'(pcpi_valid), 32'd1);
    check({v.name, ".pcpi_insn"}, pcpi_insn, v.insn);
    n = 1;
    div_seen = div_wait;
    while (!resp_valid && n < BOUND) begin
      step();
      div_seen = div_seen | div_wait;
      n++;
    end
    check({v.name, ".resp_valid_in_time"}, 32'(resp_valid), 32'd1);
    if (v.lat != 0) check({v.name, ".latency"}, 32'(n), 32'(v.lat));
    if (v.trap) check({v.name, ".div_activity"}, 32'(div_seen), 32'd0);
    check({v.name, ".pcpi_valid_dropped"}, 32'(pcpi_valid), 32'd0);
    check({v.name, ".resp_rd"}, resp_rd, v.rd);
    check({v.name, ".resp_wr"}, 32'(resp_wr), 32'(v.wr));
    check({v.name, ".resp_trap"}, 32'(resp_trap), 32'(v.trap));
    for (int i = 0; i < v.hold; i++) begin
      step();
      check({v.name, ".held_rd"}, resp_rd, v.rd);
      check({v.name, ".held_state"}, {29'd0, resp_valid, pcpi_valid, div_wait}, 32'b100);
    end
    resp_ready = 1'b1;
    check({v.name, ".req_ready_in_done"}, 32'(req_ready), 32'd0);
    step();
    resp_ready = 1'b0;
    check({v.name, ".req_ready_after"}, 32'(req_ready), 32'd1);
    check({v.name, ".resp_valid_after"}, 32'(resp_valid), 32'd0);
    check({v.name, ".busy_after"}, 32'(busy), 32'd0);
    mul_mode = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".ctrl"},
          {24'd0, req_ready, pcpi_valid, resp_valid, resp_wr, resp_trap, busy, 2'b00},
          32'b1000_0000);
    check({name, ".pcpi_insn"}, pcpi_insn, 32'd0);
    check({name, ".pcpi_rs1"}, pcpi_rs1, 32'd0);
    check({name, ".pcpi_rs2"}, pcpi_rs2, 32'd0);
    check({name, ".resp_rd"}, resp_rd, 32'd0);
  endtask

  localparam logic [31:0] I_DIV  = 32'h0220_C1B3;
  localparam logic [31:0] I_DIVU = 32'h0220_D1B3;
  localparam logic [31:0] I_REM  = 32'h0220_E1B3;
  localparam logic [31:0] I_REMU = 32'h0220_F1B3;
  localparam logic [31:0] I_MUL  = 32'h0220_81B3;
  localparam logic [31:0] I_ADD  = 32'h00B5_0533;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"divu_100_7", I_DIVU, 32'd100,       32'd7, 0, 32'd14,        1'b1, 1'b0, 0,  0};
    vecs[1] = '{"div_m7_2",   I_DIV,  32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 1'b1, 1'b0, 0,  0};
    vecs[2] = '{"rem_m7_2",   I_REM,  32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0,  0};
    vecs[3] = '{"divu_x_0",   I_DIVU, 32'h1234_5678, 32'd0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0,  0};
    vecs[4] = '{"remu_100_7", I_REMU, 32'd100,       32'd7, 0, 32'd2,         1'b1, 1'b0, 0,  0};
    vecs[5] = '{"unclaimed",  I_ADD,  32'd5,         32'd6, 0, 32'd0,         1'b0, 1'b1, 17, 0};
    vecs[6] = '{"mul_stub",   I_MUL,  32'd3,         32'd4, 1, 32'h1234_5678, 1'b1, 1'b0, 3,  0};
    vecs[7] = '{"mul_wins",   I_DIVU, 32'd100,       32'd7, 2, 32'h1234_5678, 1'b1, 1'b0, 0,  0};

    resetn = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    resetn = 1'b1;
    step();
    check_reset_outputs("idle_after_reset");

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Response held for 5 cycles: result stable, divider stays idle.
    do_op('{"divu_hold", I_DIVU, 32'd100, 32'd7, 0, 32'd14, 1'b1, 1'b0, 0, 5});

    // Reset in ISSUE cycle 10 of a divide abandons it with no response.
    begin
      logic resp_seen;
      req_insn  = I_DIVU;
      req_rs1   = 32'd100;
      req_rs2   = 32'd7;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int i = 1; i < 10; i++) step();
      check("mid_reset.busy_before", 32'(busy), 32'd1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_reset_outputs("mid_reset");
      resp_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        step();
        resp_seen = resp_seen | resp_valid | pcpi_valid;
      end
      check("mid_reset.no_response", 32'(resp_seen), 32'd0);
    end

    do_op('{"after_reset", I_DIVU, 32'd100, 32'd7, 0, 32'd14, 1'b1, 1'b0, 0, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
